gray_monitor: RTL and testbench
===============================

GRAY_MONITOR -- requirements
Module: gray_monitor

Interface
REQ-001 Parameter: N, default 5, width of the monitored Gray code word (legal range 2..16).
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 Port: clk_en  input  1  step strobe, the same signal that enables the upstream gray_Nbits counter.
REQ-005 Port: gray_in  input  N  gray_out of the upstream gray_Nbits counter.
REQ-006 Port: bin_out  output  N  registered binary decode of the last sampled gray_in.
REQ-007 Port: step_ok  output  1  one-cycle pulse: sampled value is the legal successor.
REQ-008 Port: err  output  1  one-cycle pulse: sampled value is not the legal successor.
REQ-009 Port: err_count  output  8  number of err pulses since reset, saturating.
REQ-010 Port: locked  output  1  high while a valid reference value is held (state TRACK).
REQ-011 Port: leds  output  4  board LEDs: {err_flag, locked, bin_out[1:0]}.

Function
REQ-012 The block SHALL register clk_en into smp_stb; gray_in is sampled only in cycles where smp_stb=1, i.e. one cycle after clk_en, when the counter output has settled.
REQ-013 Decode SHALL be bin[N-1]=g[N-1], bin[i]=bin[i+1] XOR g[i] for i=N-2..0.
REQ-014 The expected successor SHALL be gray(prev_bin+1 mod 2^N), where gray(b)=b XOR (b>>1); wrap from 2^N-1 to 0 is legal.
REQ-015 FSM states SHALL be IDLE, TRACK and RESYNC; reset state is IDLE.
REQ-016 IDLE/RESYNC on sample: capture gray_in as the reference, load bin_out, no step_ok/err, go to TRACK.
REQ-017 TRACK on sample, gray_in equals the expected successor: update the reference and bin_out, pulse step_ok for 1 cycle, stay in TRACK.
REQ-018 TRACK on sample, any other value, including an unchanged value: pulse err for 1 cycle, increment err_count, set err_flag, leave bin_out unchanged, go to RESYNC.
REQ-019 step_ok and err SHALL assert in the cycle after the sampling edge and SHALL never be high together.
REQ-020 err_count SHALL saturate at 255; err pulses beyond that SHALL leave it at 255.
REQ-021 err_flag SHALL be sticky until rst.
REQ-022 With no samples, all state and outputs SHALL hold.
REQ-023 clk_en held high for consecutive cycles SHALL produce one sample per cycle, each checked against the previous sample.

Reset
REQ-024 rst SHALL take priority over every other input; in a cycle with rst=1 any pending sample is discarded.
REQ-025 Reset values: state=IDLE, smp_stb=0, bin_out=0, step_ok=0, err=0, err_count=0, err_flag=0, locked=0, leds=4'b0000.
REQ-026 rst asserted mid-operation SHALL return the block to IDLE; the first sample after reset is a reference capture, not a check.

Verification (N=5)
REQ-027 Reset, then 40 strobes driven by a correct gray_Nbits -> first sample: locked=1, no pulse; next 39 samples: 39 step_ok pulses, err_count=0, leds[3]=0.
REQ-028 Wrap: reference 5'b10000 (bin 31), next sample 5'b00000 -> step_ok=1, bin_out=0.
REQ-029 Skip: reference 5'b00001, sample 5'b00010 -> err=1, err_count=1, locked=0, leds[3]=1, bin_out=1; next sample 5'b00110 -> captured, locked=1, bin_out=4, no pulse.
REQ-030 Stall: reference 5'b00011, sample 5'b00011 again -> err=1, err_count increments by 1.
REQ-031 300 consecutive illegal samples -> err_count=255, then held at 255.
REQ-032 rst=1 in the same cycle as smp_stb=1 while in TRACK -> no pulse, all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/gray_monitor.sv
// gray_monitor: watches the output of an upstream Gray-code counter and
// checks that every sampled word is the legal successor of the previous one.
// gray_in is sampled one cycle after the counter's step strobe, so the
// counter output has settled. The word is decoded to binary and a
// one-cycle step_ok or err pulse is produced. A saturating error count and
// a sticky error flag are kept for the board LEDs.
module gray_monitor #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic [N-1:0] gray_in,
    output logic [N-1:0] bin_out,
    output logic         step_ok,
    output logic         err,
    output logic [7:0]   err_count,
    output logic         locked,
    output logic [3:0]   leds
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_RESYNC = 2'd2
    } state_t;

    localparam logic [N-1:0] BIN_ONE = {{(N-1){1'b0}}, 1'b1};
    localparam logic [7:0]   CNT_MAX = 8'hFF;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         r_smp_stb;
    logic [N-1:0] r_bin;
    logic         r_step_ok;
    logic         r_err;
    logic [7:0]   r_err_count;
    logic         r_err_flag;

    logic [N-1:0] w_gray_bin;
    logic [N-1:0] w_next_bin;
    logic [N-1:0] w_exp_gray;
    logic         w_match;
    logic         w_load;
    logic         w_step;
    logic         w_err;

    // Gray-to-binary decode: binary bit i is the XOR of all Gray bits from i upward.
    always_comb begin
        w_gray_bin = '0;
        for (int i = 0; i < N; i++) begin
            w_gray_bin[i] = ^(gray_in >> i);
        end
    end

    // Expected successor is the Gray encoding of reference+1; the binary add wraps naturally.
    assign w_next_bin = r_bin + BIN_ONE;
    assign w_exp_gray = w_next_bin ^ (w_next_bin >> 1);
    assign w_match    = (gray_in == w_exp_gray);

    // Next-state and per-sample decisions; nothing happens in cycles without a sample.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_err       = 1'b0;
        if (r_smp_stb) begin
            case (r_state)
                ST_IDLE, ST_RESYNC: begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_TRACK;
                end
                ST_TRACK: begin
                    if (w_match) begin
                        w_load = 1'b1;
                        w_step = 1'b1;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_RESYNC;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State register; reset wins over any pending sample.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sample strobe, decoded reference, result pulses and error bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_smp_stb   <= 1'b0;
            r_bin       <= '0;
            r_step_ok   <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_err_flag  <= 1'b0;
        end else begin
            r_smp_stb <= clk_en;
            r_step_ok <= w_step;
            r_err     <= w_err;
            if (w_load) begin
                r_bin <= w_gray_bin;
            end
            if (w_err) begin
                r_err_flag <= 1'b1;
                if (r_err_count != CNT_MAX) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign bin_out   = r_bin;
    assign step_ok   = r_step_ok;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign locked    = (r_state == ST_TRACK);
    assign leds      = {r_err_flag, locked, r_bin[1:0]};

endmodule

// File: tb/tb_gray_monitor.sv
// Bench for gray_monitor (N=5): directed table of single samples plus
// hand-written multi-cycle sequences (free-running counter, hold, reset
// during a pending sample, error-count saturation).
module tb_gray_monitor;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic         clk_en;
    logic [N-1:0] gray_in;
    logic [N-1:0] bin_out;
    logic         step_ok;
    logic         err;
    logic [7:0]   err_count;
    logic         locked;
    logic [3:0]   leds;

    // Upstream counter model and manual override of gray_in.
    logic [N-1:0] cnt;
    logic [N-1:0] man_g;
    logic         use_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int n_err    = 0;
    int n_both   = 0;

    typedef struct {
        logic [N-1:0] g;
        logic         step;
        logic         err;
        logic [N-1:0] bin;
        logic [7:0]   cnt;
        logic         locked;
        logic [3:0]   leds;
    } vec_t;

    vec_t vecs[12];

    gray_monitor #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_en    (clk_en),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .step_ok   (step_ok),
        .err       (err),
        .err_count (err_count),
        .locked    (locked),
        .leds      (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (clk_en) cnt <= cnt + 5'd1;
    end

    assign gray_in = use_cnt ? (cnt ^ (cnt >> 1)) : man_g;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, land 1 time unit after the edge, tally pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        if (step_ok === 1'b1) n_step++;
        if (err === 1'b1) n_err++;
        if (step_ok === 1'b1 && err === 1'b1) n_both++;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        clk_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // One isolated sample: strobe for one cycle, gray_in held, result visible after two edges.
    task automatic do_sample(input logic [N-1:0] g);
        man_g  = g;
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        tick();
    endtask

    task automatic check_outputs(input string tag, input logic s, input logic e, input logic [N-1:0] b,
                                 input logic [7:0] c, input logic l, input logic [3:0] ld);
        check({tag, " step_ok"},   32'(step_ok),   32'(s));
        check({tag, " err"},       32'(err),       32'(e));
        check({tag, " bin_out"},   32'(bin_out),   32'(b));
        check({tag, " err_count"}, 32'(err_count), 32'(c));
        check({tag, " locked"},    32'(locked),    32'(l));
        check({tag, " leds"},      32'(leds),      32'(ld));
    endtask

    initial begin
        rst     = 1'b0;
        clk_en  = 1'b0;
        man_g   = '0;
        use_cnt = 1'b0;
        #1;

        // ---- Reset values ----
        do_reset();
        check_outputs("reset", 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 4'b0000);

        // ---- 40 strobes from a correct counter, consecutive clk_en ----
        use_cnt = 1'b1;
        clk_en  = 1'b1;
        n_step  = 0;
        n_err   = 0;
        n_both  = 0;
        for (int cyc = 0; cyc < 45; cyc++) begin
            if (cyc == 40) clk_en = 1'b0;
            tick();
            if (cyc == 1) begin
                check("run first sample locked", 32'(locked), 32'd1);
                check("run first sample no pulse", 32'(step_ok | err), 32'd0);
            end
        end
        check("run step_ok pulses", 32'(n_step), 32'd39);
        check("run err pulses", 32'(n_err), 32'd0);
        check("run err_count", 32'(err_count), 32'd0);
        check("run leds[3]", 32'(leds[3]), 32'd0);
        check("run final bin_out", 32'(bin_out), 32'd8);
        check("run locked", 32'(locked), 32'd1);

        // ---- No samples: everything holds even though gray_in moves ----
        use_cnt = 1'b0;
        n_step  = 0;
        n_err   = 0;
        for (int i = 0; i < 5; i++) begin
            man_g = 5'(i * 7 + 3);
            tick();
        end
        check("hold pulses", 32'(n_step + n_err), 32'd0);
        check("hold bin_out", 32'(bin_out), 32'd8);
        check("hold locked", 32'(locked), 32'd1);

        // ---- Table of isolated samples: capture, step, stall, skip, wrap ----
        vecs[0]  = '{5'b00001, 1'b0, 1'b0, 5'd1,  8'd0, 1'b1, 4'b0101}; // capture bin 1
        vecs[1]  = '{5'b00011, 1'b1, 1'b0, 5'd2,  8'd0, 1'b1, 4'b0110}; // legal step
        vecs[2]  = '{5'b00011, 1'b0, 1'b1, 5'd2,  8'd1, 1'b0, 4'b1010}; // stall
        vecs[3]  = '{5'b00110, 1'b0, 1'b0, 5'd4,  8'd1, 1'b1, 4'b1100}; // resync capture
        vecs[4]  = '{5'b00001, 1'b0, 1'b1, 5'd4,  8'd2, 1'b0, 4'b1000}; // illegal
        vecs[5]  = '{5'b00001, 1'b0, 1'b0, 5'd1,  8'd2, 1'b1, 4'b1101}; // reference 00001
        vecs[6]  = '{5'b00010, 1'b0, 1'b1, 5'd1,  8'd3, 1'b0, 4'b1001}; // skip
        vecs[7]  = '{5'b00110, 1'b0, 1'b0, 5'd4,  8'd3, 1'b1, 4'b1100}; // capture bin 4
        vecs[8]  = '{5'b10000, 1'b0, 1'b1, 5'd4,  8'd4, 1'b0, 4'b1000}; // illegal
        vecs[9]  = '{5'b10000, 1'b0, 1'b0, 5'd31, 8'd4, 1'b1, 4'b1111}; // reference bin 31
        vecs[10] = '{5'b00000, 1'b1, 1'b0, 5'd0,  8'd4, 1'b1, 4'b1100}; // wrap 31 -> 0
        vecs[11] = '{5'b00001, 1'b1, 1'b0, 5'd1,  8'd4, 1'b1, 4'b1101}; // step after wrap
        do_reset();
        for (int v = 0; v < 12; v++) begin
            do_sample(vecs[v].g);
            check_outputs($sformatf("vec%0d", v), vecs[v].step, vecs[v].err, vecs[v].bin,
                          vecs[v].cnt, vecs[v].locked, vecs[v].leds);
        end

        // ---- rst in the same cycle as a pending sample in TRACK ----
        man_g  = 5'b00011;
        clk_en = 1'b1;
        tick();
        clk_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs("rst_pending", 1'b0, 1'b0, 5'd0, 8'd0, 1'b0, 4'b0000);
        tick();
        check("rst_pending discarded pulse", 32'(step_ok | err), 32'd0);
        check("rst_pending discarded locked", 32'(locked), 32'd0);
        do_sample(5'b00011);
        check_outputs("post_rst capture", 1'b0, 1'b0, 5'd2, 8'd0, 1'b1, 4'b0110);

        // ---- Saturation: constant gray_in, 600 samples -> 300 errors ----
        do_reset();
        man_g  = 5'b00101;
        n_step = 0;
        n_err  = 0;
        n_both = 0;
        clk_en = 1'b1;
        for (int cyc = 0; cyc < 604; cyc++) begin
            if (cyc == 600) clk_en = 1'b0;
            tick();
        end
        check("sat err pulses", 32'(n_err), 32'd300);
        check("sat err_count", 32'(err_count), 32'd255);
        check("sat err_flag", 32'(leds[3]), 32'd1);
        n_err  = 0;
        clk_en = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            if (cyc == 20) clk_en = 1'b0;
            tick();
        end
        check("sat extra err pulses", 32'(n_err), 32'd10);
        check("sat err_count held", 32'(err_count), 32'd255);
        check("never step_ok and err together", 32'(n_both), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
